// File: rtl/mips_instr_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_instr_encoder: packs symbolic instruction descriptors into MIPS words
// and writes them to consecutive instruction-memory addresses from 0.
// Rev 1.0
// ---------------------------------------------------------------------------
module mips_instr_encoder #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       jaddr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    S_ACCEPT = 2'd0,
    S_WRITE  = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            last_q, last_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            err_q, err_d;

  logic [31:0]     enc_word;
  logic            enc_legal;

  always_comb begin
    enc_legal = 1'b1;
    enc_word  = 32'h0;
    case (op_sel)
      4'd0:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      4'd1:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      4'd2:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
      4'd3:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
      4'd4:    enc_word = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      4'd5:    enc_word = {6'b100011, rs, rt, imm};
      4'd6:    enc_word = {6'b101011, rs, rt, imm};
      4'd7:    enc_word = {6'b000100, rs, rt, imm};
      4'd8:    enc_word = {6'b001000, rs, rt, imm};
      4'd9:    enc_word = {6'b000010, jaddr};
      default: enc_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    wdata_d  = wdata_q;
    last_d   = last_q;
    count_d  = count_q;
    err_d    = err_q;
    in_ready = 1'b0;
    imem_we  = 1'b0;
    case (state_q)
      S_ACCEPT: begin
        // restart wins over the handshake, so the descriptor stays pending
        in_ready = ~restart;
        if (in_valid && in_ready) begin
          if (enc_legal) begin
            wdata_d = enc_word;
            last_d  = in_last;
            state_d = S_WRITE;
          end else begin
            err_d = 1'b1;
            if (in_last) state_d = S_DONE;
          end
        end
      end
      S_WRITE: begin
        imem_we = ~restart;
        count_d = count_q + CNT_ONE;
        state_d = (last_q || count_q == LAST_CNT) ? S_DONE : S_ACCEPT;
      end
      S_DONE: ;
      default: state_d = S_ACCEPT;
    endcase
    if (restart) begin
      state_d = S_ACCEPT;
      wdata_d = 32'h0;
      last_d  = 1'b0;
      count_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_ACCEPT;
      wdata_q <= 32'h0;
      last_q  <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // The write address is the number of words already written
  assign imem_addr  = count_q[ADDR_W-1:0];
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign done       = (state_q == S_DONE);
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
`default_nettype none
// Testbench for mips_instr_encoder: randomized descriptors against a
// reference encoder, with a write scoreboard drained by a monitor.
module tb_mips_instr_encoder;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset_n, restart, in_valid, in_ready, in_last;
  logic [3:0]    op_sel;
  logic [4:0]    rs, rt, rd;
  logic [15:0]   imm;
  logic [25:0]   jaddr;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          done, err;

  always #5 clk = ~clk;

  mips_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .restart(restart), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last), .op_sel(op_sel), .rs(rs),
    .rt(rt), .rd(rd), .imm(imm), .jaddr(jaddr), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .count(count),
    .done(done), .err(err)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   word;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0, checks = 0, strobes = 0, m_total = 0;
  int   m_count = 0;
  bit   m_err = 0, m_done = 0;

  function automatic logic [31:0] ref_word(int op, int r_s, int r_t, int r_d,
                                           int im, int ja);
    int unsigned funct[5] = '{32, 34, 36, 37, 42};
    int unsigned opc[4]   = '{35, 43, 4, 8};
    int unsigned w;
    if (op < 5)
      w = (r_s << 21) | (r_t << 16) | (r_d << 11) | funct[op];
    else if (op < 9)
      w = (opc[op-5] << 26) | (r_s << 21) | (r_t << 16) | (im & 32'hFFFF);
    else
      w = (2 << 26) | (ja & 32'h03FF_FFFF);
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_accept(input int op, input int r_s, input int r_t,
                              input int r_d, input int im, input int ja,
                              input bit last);
    exp_t e;
    if (op < 10) begin
      e.addr = AW'(m_count);
      e.word = ref_word(op, r_s, r_t, r_d, im, ja);
      sb.push_back(e);
      m_count++;
      m_total++;
      if (last || m_count == DEPTH) m_done = 1;
    end else begin
      m_err = 1;
      if (last) m_done = 1;
    end
  endtask

  task automatic model_clear();
    m_count = 0;
    m_err   = 0;
    m_done  = 0;
  endtask

  always @(negedge clk) begin
    if (reset_n && imem_we) begin
      strobes++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: addr %0d data 0x%h, nothing expected",
                 imem_addr, imem_wdata);
      end else begin
        mon_e = sb.pop_front();
        if (imem_addr !== mon_e.addr || imem_wdata !== mon_e.word || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL write: addr %0d data 0x%h ready %b, expected addr %0d data 0x%h ready 0",
                   imem_addr, imem_wdata, in_ready, mon_e.addr, mon_e.word);
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  // abort: 0 none, 1 restart during WRITE, 2 reset during WRITE.
  task automatic send(input int op, input int r_s, input int r_t, input int r_d,
                      input int im, input int ja, input bit last,
                      input int budget, input int abort, output bit acc);
    op_sel   = op[3:0];
    rs       = r_s[4:0];
    rt       = r_t[4:0];
    rd       = r_d[4:0];
    imm      = im[15:0];
    jaddr    = ja[25:0];
    in_last  = last;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int c = 0; c < budget && !acc; c++) begin
      #1;
      if (in_ready) begin
        acc = 1'b1;
        model_accept(op, r_s, r_t, r_d, im, ja, last);
      end else begin
        @(negedge clk);
      end
    end
    if (acc) begin
      @(posedge clk);
      if (abort != 0) begin
        #2;
        if (abort == 1) restart = 1'b1;
        else            reset_n = 1'b0;
        if (op < 10) begin
          void'(sb.pop_back());
          m_total--;
        end
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("strobe_latency", {31'b0, imem_we}, {31'b0, (op < 10 && abort == 0)});
      if (abort != 0) begin
        @(negedge clk);
        restart = 1'b0;
        reset_n = 1'b1;
        model_clear();
      end
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic restart_pulse();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    model_clear();
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(m_count));
    chk({tag, "_done"}, {31'b0, done}, {31'b0, m_done});
    chk({tag, "_err"}, {31'b0, err}, {31'b0, m_err});
    chk({tag, "_ready"}, {31'b0, in_ready}, {31'b0, !m_done});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit exp_acc;
    logic [31:0] seq_exp[5] = '{32'h8C080004, 32'hAFBF0008, 32'h1022FFFF,
                                32'h20010005, 32'h08000010};
    int seq_op[5]  = '{5, 6, 7, 8, 9};
    int seq_rs[5]  = '{0, 29, 1, 0, 0};
    int seq_rt[5]  = '{8, 31, 2, 1, 0};
    int seq_imm[5] = '{4, 8, 'hFFFF, 5, 0};
    int op, gap;

    reset_n = 1'b0; restart = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    op_sel = '0; rs = '0; rt = '0; rd = '0; imm = '0; jaddr = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_we", {31'b0, imem_we}, 32'd0);
    chk("reset_addr", 32'(imem_addr), 32'd0);
    chk("reset_wdata", imem_wdata, 32'd0);
    check_status("reset");
    @(negedge clk);

    // single add
    send(0, 1, 2, 3, 0, 0, 1'b0, 4, 0, acc);
    chk("add_acc", {31'b0, acc}, 32'd1);
    chk("add_wdata", imem_wdata, 32'h00221820);
    chk("add_addr", 32'(imem_addr), 32'd0);
    @(negedge clk);
    check_status("add");
    restart_pulse();

    // five-word program ending in j
    for (int i = 0; i < 5; i++) begin
      send(seq_op[i], seq_rs[i], seq_rt[i], 0, seq_imm[i], 'h10, i == 4, 4, 0, acc);
      chk("seq_wdata", imem_wdata, seq_exp[i]);
      chk("seq_addr", 32'(imem_addr), 32'(i));
    end
    @(negedge clk);
    check_status("seq");
    chk("seq_done_const", {31'b0, done}, 32'd1);
    restart_pulse();

    // illegal descriptor between two legal ones
    send(0, 4, 5, 6, 0, 0, 1'b0, 4, 0, acc);
    send(12, 1, 1, 1, 0, 0, 1'b0, 4, 0, acc);
    send(1, 7, 8, 9, 0, 0, 1'b0, 4, 0, acc);
    chk("illegal_addr", 32'(imem_addr), 32'd1);
    @(negedge clk);
    check_status("illegal");
    chk("illegal_err", {31'b0, err}, 32'd1);
    restart_pulse();

    // fill memory: extra descriptors must be refused
    for (int i = 0; i < DEPTH + 2; i++) begin
      send(8, i, i + 1, 0, i * 3, 0, 1'b0, 3, 0, acc);
      chk("fill_acc", {31'b0, acc}, {31'b0, i < DEPTH});
    end
    @(negedge clk);
    check_status("fill");
    restart_pulse();

    // restart aborts a write; next word lands at address 0
    send(2, 3, 4, 5, 0, 0, 1'b0, 4, 1, acc);
    chk("rabort_count", 32'(count), 32'd0);
    send(3, 3, 4, 5, 0, 0, 1'b0, 4, 0, acc);
    chk("rabort_addr", 32'(imem_addr), 32'd0);
    @(negedge clk);
    restart_pulse();

    // reset mid-WRITE, then restart with a descriptor offered
    send(4, 9, 10, 11, 0, 0, 1'b0, 4, 2, acc);
    #1;
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    check_status("rst");
    @(negedge clk);
    restart = 1'b1; in_valid = 1'b1; op_sel = 4'd0;
    #1;
    chk("restart_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    restart = 1'b0; in_valid = 1'b0;
    #1;
    chk("restart_no_we", {31'b0, imem_we}, 32'd0);
    check_status("restart");
    @(negedge clk);

    // randomized program stream with idle gaps
    for (int i = 0; i < 60; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      op = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      exp_acc = !m_done;
      send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 65535), $urandom, $urandom_range(0, 5) == 0, 4, 0, acc);
      chk("rand_acc", {31'b0, acc}, {31'b0, exp_acc});
      if (m_done) begin
        @(negedge clk);
        check_status("rand");
        restart_pulse();
      end
    end
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("strobe_total", 32'(strobes), 32'(m_total));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Sequential instruction encoder and loader: the inverse of the controller's opcode/funct decode path. Accepts symbolic instruction descriptors (operation select plus register/immediate fields) over a valid/ready handshake, packs each into a 32-bit MIPS word (R-type add/sub/and/or/slt, lw, sw, beq, addi, j), and writes the words to consecutive instruction-memory addresses starting at 0. Sits between the testbench/bootloader stimulus source and the instruction memory's write port, so programs exercising the controller are generated in hardware.

## Interface
- DEPTH, 64, number of instruction-memory words; load stops when full.
- ADDR_W, 6, instruction-memory word-address width; ceil(log2(DEPTH)).

- clk  in  1  single clock, all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- restart  in  1  synchronous pulse: clear address, count, done, err; return to ACCEPT.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  encoder can accept a descriptor this cycle.
- in_last  in  1  descriptor is the final one of the program.
- op_sel  in  4  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 lw, 6 sw, 7 beq, 8 addi, 9 j, 10–15 illegal.
- rs, rt, rd  in  5 each  register fields.
- imm  in  16  immediate (lw/sw/beq/addi).
- jaddr  in  26  jump target field (j).
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written since reset/restart.
- done  out  1  load finished (last seen or memory full).
- err  out  1  sticky: an illegal op_sel was accepted.

## Operation
- States: ACCEPT, WRITE, DONE.
- ACCEPT: in_ready=1. On in_valid&in_ready: if op_sel legal, register encoded word and in_last, go WRITE; if illegal, set err, write nothing, stay ACCEPT unless in_last (then DONE).
- WRITE: in_ready=0, imem_we=1 with registered addr/wdata for exactly one cycle. Next: count+1, address+1; go DONE if registered in_last or count reaches DEPTH, else ACCEPT.
- DONE: in_ready=0, imem_we=0, done=1; holds until restart or reset.
- Encoding: R-type = {6'b000000, rs, rt, rd, 5'b00000, funct}, funct add 100000, sub 100010, and 100100, or 100101, slt 101010. I-type = {op, rs, rt, imm}, op lw 100011, sw 101011, beq 000100, addi 001000. j = {000010, jaddr}. Unused fields ignored.
- Address never wraps: after DEPTH writes, further descriptors are refused (in_ready=0).
- restart has priority over the handshake in the same cycle; the descriptor is not consumed. restart during WRITE aborts the write (imem_we forced 0 that cycle).

## Timing
- Reset (async, immediate): state ACCEPT, in_ready=1 after deassertion, imem_we=0, imem_addr=0, imem_wdata=0, count=0, done=0, err=0.
- Handshake at cycle N -> imem_we high in cycle N+1 -> in_ready high again in N+2. Max throughput one word per 2 cycles.
- imem_addr/imem_wdata stable through the whole WRITE cycle; memory samples at the rising edge ending it.
- count and done update at the edge ending WRITE; done visible the cycle after the final write.
- Reset asserted mid-WRITE: strobe drops immediately, no partial write.

## Test plan
- add rs=1 rt=2 rd=3 -> one-cycle imem_we, addr 0, wdata 0x00221820; count=1.
- Sequence lw rs=0 rt=8 imm=4; sw rs=29 rt=31 imm=8; beq rs=1 rt=2 imm=0xFFFF; addi rs=0 rt=1 imm=5; j jaddr=0x10 (last) -> addrs 0..4, words 0x8C080004, 0xAFBF0008, 0x1022FFFF, 0x20010005, 0x08000010; done=1, count=5.
- op_sel=12 between two legal descriptors -> err=1 sticky, no write, second legal word lands at addr 1.
- DEPTH=4, 6 descriptors, in_valid held high -> 4 writes, done=1, in_ready=0, count=4, no fifth strobe.
- in_valid toggled randomly, in_ready observed -> no descriptor lost or duplicated; in_ready low in every WRITE cycle.
- reset_n low mid-WRITE, then restart during ACCEPT with in_valid high -> all outputs reset values; restart cycle consumes no descriptor.
